// File: rtl/bus_pkg.sv
// Shared types and constants for the bus arbiter and its round-robin picker.
package bus_pkg;

   localparam int N_REQ = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_TURN  = 2'd2
   } state_t;

   localparam logic [4:0] CS_NONE = 5'b00000;
   localparam logic [4:0] CS_REQ0 = 5'b11000;
   localparam logic [4:0] CS_REQ1 = 5'b10100;
   localparam logic [4:0] CS_REQ2 = 5'b10010;
   localparam logic [4:0] CS_REQ3 = 5'b10001;

   function automatic logic [4:0] cs_code(input logic [1:0] idx);
      logic [4:0] code;
      case (idx)
         2'd0:    code = CS_REQ0;
         2'd1:    code = CS_REQ1;
         2'd2:    code = CS_REQ2;
         default: code = CS_REQ3;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: search starts one past the last owner,
// so the last owner itself has the lowest priority.
module rr_pick
   import bus_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [1:0]       last_owner,
   output logic             valid,
   output logic [1:0]       winner
);

   logic [1:0] w_idx;

   // Walk from farthest to nearest candidate so the nearest one wins.
   always_comb begin
      valid  = 1'b0;
      winner = 2'd0;
      w_idx  = 2'd0;
      for (int k = 4; k >= 1; k--) begin
         w_idx = last_owner + 2'(k);
         if (req[w_idx]) begin
            valid  = 1'b1;
            winner = w_idx;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with per-owner hold limit and a one-cycle bus
// turnaround (TURN) between every pair of owners.
//
// state    | meaning
// IDLE     | no owner, arbitrating every cycle
// GRANT    | one owner drives the bus, hold counter running
// TURN     | single turnaround cycle, all selects off, re-arbitrate
module bus_arbiter #(
   parameter int MAX_HOLD = 8,
   parameter int N_REQ    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] done,
   output logic [4:0]       cs,
   output logic [N_REQ-1:0] gnt,
   output logic             busy,
   output logic             timeout
);
   import bus_pkg::*;

   state_t     r_state;
   logic [1:0] r_owner;
   logic [1:0] r_last;
   logic [3:0] r_hold;

   logic       w_pick_valid;
   logic [1:0] w_pick_winner;
   logic       w_at_max;
   logic       w_release;
   logic       w_forced;

   rr_pick u_rr_pick (
      .req        (req),
      .last_owner (r_last),
      .valid      (w_pick_valid),
      .winner     (w_pick_winner)
   );

   assign w_at_max  = (r_hold == 4'(MAX_HOLD));
   assign w_release = done[r_owner] | ~req[r_owner] | w_at_max;
   // A voluntary release in the same cycle as the limit is not a timeout.
   assign w_forced  = w_at_max & req[r_owner] & ~done[r_owner];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_owner <= 2'd0;
         r_last  <= 2'd3;
         r_hold  <= 4'd0;
         gnt     <= '0;
         cs      <= CS_NONE;
         busy    <= 1'b0;
         timeout <= 1'b0;
      end else begin
         timeout <= 1'b0;
         case (r_state)
            ST_IDLE, ST_TURN: begin
               if (w_pick_valid) begin
                  r_state <= ST_GRANT;
                  r_owner <= w_pick_winner;
                  r_hold  <= 4'd1;
                  gnt     <= N_REQ'(1) << w_pick_winner;
                  cs      <= cs_code(w_pick_winner);
                  busy    <= 1'b1;
               end else begin
                  r_state <= ST_IDLE;
                  r_hold  <= 4'd0;
               end
            end
            ST_GRANT: begin
               if (w_release) begin
                  r_state <= ST_TURN;
                  r_last  <= r_owner;
                  r_hold  <= 4'd0;
                  gnt     <= '0;
                  cs      <= CS_NONE;
                  busy    <= 1'b0;
                  timeout <= w_forced;
               end else begin
                  r_hold  <= r_hold + 4'd1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_hold  <= 4'd0;
               gnt     <= '0;
               cs      <= CS_NONE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
